// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC, (x, y) -> magnitude and atan2(y, x).
// Define CORDIC_VEC_GAIN_COMP_EN to add a GAIN state that removes the CORDIC gain K from magnitude.
module cordic_vectoring #(
  parameter int WIDTH = 16,
  parameter int ITERATIONS = 15,
  parameter int ANGLE_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [WIDTH-1:0]       x_in,
  input  logic signed [WIDTH-1:0]       y_in,
  output logic [WIDTH-1:0]              magnitude,
  output logic signed [ANGLE_WIDTH-1:0] angle,
  output logic                          busy,
  output logic                          done
);
  localparam int XW = WIDTH + 2;
  localparam int SHL = ANGLE_WIDTH > 33 ? ANGLE_WIDTH - 33 : 0;
  localparam int SHR = ANGLE_WIDTH < 33 ? 33 - ANGLE_WIDTH : 0;
  // Angle constants are held at 2^30 per radian and rescaled to 2^(ANGLE_WIDTH-3).
  localparam logic [31:0] ATAN30 [10] = '{
    32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6, 32'h03FEAB76,
    32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55, 32'h003FFFEA, 32'h001FFFFD
  };
  localparam logic [63:0] PI64 = (64'hC90FDAA2 << SHL) >> SHR;
  localparam logic signed [ANGLE_WIDTH-1:0] PI = PI64[ANGLE_WIDTH-1:0];
  localparam logic signed [XW-1:0] MAXV = XW'((64'd1 << (WIDTH - 1)) - 64'd1);

  function automatic logic signed [ANGLE_WIDTH-1:0] atan_tab(input logic [4:0] k);
    logic [63:0] t;
    t = k < 5'd10 ? 64'(ATAN30[k[3:0]]) : (64'd1 << (5'd30 - k)) - 64'd1;
    t = (t << SHL) >> SHR;
    return t[ANGLE_WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ITER,
`ifdef CORDIC_VEC_GAIN_COMP_EN
    GAIN,
`endif
    FINISH
  } state_t;

  state_t                        state_q, state_d;
  logic signed [XW-1:0]          x_q, x_d, y_q, y_d;
  logic signed [ANGLE_WIDTH-1:0] z_q, z_d;
  logic [4:0]                    i_q, i_d;
  logic                          zero_q, zero_d;
  logic [WIDTH-1:0]              mag_q, mag_d;
  logic signed [ANGLE_WIDTH-1:0] ang_q, ang_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic signed [XW-1:0]          xe, ye, xs, ys;
  logic signed [ANGLE_WIDTH-1:0] at;
  logic [WIDTH-1:0]              sat;

  assign xe = XW'(x_in);
  assign ye = XW'(y_in);
  assign xs = x_q >>> i_q;
  assign ys = y_q >>> i_q;
  assign at = atan_tab(i_q);
  assign sat = x_q > MAXV ? MAXV[WIDTH-1:0] : x_q[WIDTH-1:0];

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam logic [31:0] INVK30 = 32'h26DD3B6A;
  localparam logic signed [XW-1:0] INV_K = XW'(INVK30 >> (32 - WIDTH));
  logic signed [2*XW-1:0] prod;
  assign prod = (2*XW)'(x_q) * (2*XW)'(INV_K);
`endif

  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    zero_d = zero_q;
    mag_d = mag_q;
    ang_d = ang_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ITER;
        x_d = x_in[WIDTH-1] ? -xe : xe;
        y_d = x_in[WIDTH-1] ? -ye : ye;
        z_d = !x_in[WIDTH-1] ? '0 : y_in[WIDTH-1] ? -PI : PI;
        zero_d = x_in == '0 && y_in == '0;
        i_d = '0;
        busy_d = 1'b1;
      end
      ITER: begin
        x_d = y_q[XW-1] ? x_q - ys : x_q + ys;
        y_d = y_q[XW-1] ? y_q + xs : y_q - xs;
        z_d = y_q[XW-1] ? z_q - at : z_q + at;
        i_d = i_q + 5'd1;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        if (i_q == 5'(ITERATIONS - 1)) state_d = GAIN;
`else
        if (i_q == 5'(ITERATIONS - 1)) state_d = FINISH;
`endif
      end
`ifdef CORDIC_VEC_GAIN_COMP_EN
      GAIN: begin
        x_d = prod[WIDTH-2 +: XW];
        state_d = FINISH;
      end
`endif
      FINISH: begin
        mag_d = zero_q ? '0 : sat;
        ang_d = zero_q ? '0 : z_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
      zero_q <= 1'b0;
      mag_q <= '0;
      ang_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      zero_q <= zero_d;
      mag_q <= mag_d;
      ang_q <= ang_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign magnitude = mag_q;
  assign angle = ang_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: table-driven scoreboard bench for cordic_vectoring against a real-number atan2/magnitude model.
module tb_cordic_vectoring;
  localparam int W = 16;
  localparam int IT = 15;
  localparam int AW = 32;
  localparam int ATOL = 32'h20000;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int LAT = IT + 2;
  localparam bit GC = 1'b1;
`else
  localparam int LAT = IT + 1;
  localparam bit GC = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic [W-1:0] magnitude;
  logic signed [AW-1:0] angle;
  logic busy, done;

  always #5 clock = ~clock;

  cordic_vectoring #(.WIDTH(W), .ITERATIONS(IT), .ANGLE_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .magnitude(magnitude), .angle(angle), .busy(busy), .done(done)
  );

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    int ang;
    int atol;
    int mag;
    int mtol;
  } vec_t;

  vec_t tab[19];
  vec_t sb[$];
  int nt = 0, nf = 0;
  int cyc = 0, acc_cyc = 0, ndone = 0, last_done = 0;
  bit abort = 1'b0;

  function automatic vec_t mk(input int x, input int y);
    vec_t v;
    real r, kn, m;
    kn = 1.0;
    for (int k = 0; k < IT; k++) kn = kn * $sqrt(1.0 + 2.0 ** (-2 * k));
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    m = GC ? r : kn * r;
    v.x = x[W-1:0];
    v.y = y[W-1:0];
    v.ang = (x == 0 && y == 0) ? 0 : $rtoi($atan2(real'(y), real'(x)) * 536870912.0);
    v.atol = (x == 0 && y == 0) ? 0 : ATOL;
    v.mag = m > 32767.0 ? 32767 : $rtoi(m + 0.5);
    v.mtol = (x == 0 && y == 0) ? 0 : (GC ? 8 : 12);
    return v;
  endfunction

  task automatic chk(input string n, input longint act, input longint exp, input longint tol);
    nt++;
    if ((act > exp ? act - exp : exp - act) > tol) begin
      nf++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", n, act, exp, tol);
    end
  endtask

  task automatic chk_ang(input string n, input logic [AW-1:0] act, input logic [AW-1:0] exp, input int tol);
    int d;
    d = int'(act - exp);
    nt++;
    if (d > tol || d < -tol) begin
      nf++;
      $display("FAIL %s: got 0x%08h, want 0x%08h +/- 0x%0h", n, act, exp, tol);
    end
  endtask

  initial begin
    bit busy_prev;
    vec_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        busy_prev = 1'b0;
        continue;
      end
      if (busy && !busy_prev) acc_cyc = cyc;
      if (busy_prev && !busy && !abort) chk("busy_falls_with_done", done, 1, 0);
      if (done) begin
        ndone++;
        last_done = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          chk_ang($sformatf("angle(%0d,%0d)", e.x, e.y), angle, e.ang, e.atol);
          chk($sformatf("magnitude(%0d,%0d)", e.x, e.y), magnitude, e.mag, e.mtol);
          chk("latency", cyc - acc_cyc, LAT, 0);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic send(input vec_t v);
    for (int k = 0; k < 4 * LAT && busy; k++) @(negedge clock);
    start = 1'b1;
    x_in = v.x;
    y_in = v.y;
    sb.push_back(v);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * LAT && sb.size() != 0; k++) @(negedge clock);
    chk("drain_timeout", sb.size(), 0, 0);
  endtask

  initial begin
    int n0, d1;
    real a;
    tab[0] = mk(16'h4000, 0);
    tab[1] = mk(16'h2D41, 16'h2D41);
    tab[2] = mk(-16'h4000, 0);
    tab[3] = mk(-16'h2D41, -16'h2D41);
    tab[4] = mk(16'h7FFF, 16'h7FFF);
    tab[5] = mk(0, 0);
    tab[6] = mk(-32768, 0);
    tab[7] = mk(0, 16'h3000);
    tab[8] = mk(0, -16'h3000);
    tab[9] = mk(16'h1000, -16'h3800);
    tab[10] = mk(-16'h3000, 16'h2000);
    for (int i = 11; i < 19; i++) begin
      a = (real'($urandom_range(0, 1999999) + 1) / 1.0e6 - 1.0) * 3.141592653589793;
      tab[i] = mk($rtoi($floor(16384.0 * $cos(a) + 0.5)), $rtoi($floor(16384.0 * $sin(a) + 0.5)));
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_magnitude", magnitude, 0, 0);
    chk("reset_angle", angle, 0, 0);
    chk("reset_busy", busy, 0, 0);
    chk("reset_done", done, 0, 0);

    for (int i = 0; i < 19; i++) begin
      send(tab[i]);
      drain();
    end

    n0 = ndone;
    send(tab[1]);
    repeat (5) @(negedge clock);
    start = 1'b1;
    x_in = 16'h1234;
    y_in = -16'h0567;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (LAT + 5) @(negedge clock);
    chk("start_during_busy_single_done", ndone - n0, 1, 0);

    abort = 1'b1;
    n0 = ndone;
    start = 1'b1;
    x_in = 16'h3000;
    y_in = 16'h1000;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_magnitude", magnitude, 0, 0);
    chk("abort_angle", angle, 0, 0);
    chk("abort_busy", busy, 0, 0);
    chk("abort_done", done, 0, 0);
    repeat (LAT + 5) @(negedge clock);
    chk("abort_no_done", ndone - n0, 0, 0);
    abort = 1'b0;

    send(tab[3]);
    drain();

    n0 = ndone;
    sb.push_back(tab[2]);
    sb.push_back(tab[2]);
    start = 1'b1;
    x_in = tab[2].x;
    y_in = tab[2].y;
    for (int k = 0; k < 4 * LAT && ndone < n0 + 1; k++) @(negedge clock);
    d1 = last_done;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 4 * LAT && ndone < n0 + 2; k++) @(negedge clock);
    chk("held_start_done_count", ndone - n0, 2, 0);
    chk("held_start_period", last_done - d1, LAT + 1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", nt, nf);
    $fatal(1);
  end
endmodule
